pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the hold

---
 rtl/pipeline_hazard_controller_pkg.sv | 14 +
 rtl/pipeline_hazard_controller_hazard_detect_unit.sv | 18 +
 rtl/pipeline_hazard_controller.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared FSM state encoding and default widths for the hazard sequencer
package pipeline_hazard_controller_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int FLUSH_CNT_W    = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect_unit.sv
// hazard_detect_unit: combinational load-use compare between the load in EX and the sources in ID
module hazard_detect_unit
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  load_use
);

  // $zero is never a real producer, so a load into it cannot cause a hazard
  assign load_use = ex_mem_read & (|ex_rt) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: prioritised stall/flush sequencer for the 5-stage pipeline
// with a saturating stall counter and a sticky data-memory timeout flag.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_reads_hilo,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  muldiv_busy,
  input  logic                  dmem_busy,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  hold_id_ex,
  output logic                  hold_ex_mem,
  output logic                  hold_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  mem_timeout
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]          TO_MAX  = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0]          TO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [FLUSH_CNT_W-1:0] FL_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic                   timeout_q, timeout_d;
  logic                   load_use;
  logic                   md_stall;
  logic                   flush_pend;
  logic                   hold_all;
  logic                   flush_fe;
  logic                   stall_fe;

  hazard_detect_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rt      (ex_rt),
    .load_use   (load_use)
  );

  // A flush interrupted by a memory wait keeps its remaining count while parked in MEM_WAIT
  always_comb begin
    md_stall   = muldiv_busy & id_reads_hilo;
    flush_pend = (state_q == FLUSH) | ((state_q == MEM_WAIT) & (|fl_cnt_q));
    hold_all   = reset & dmem_busy;
    flush_fe   = ~reset | (~dmem_busy & (ex_branch_taken | flush_pend));
    stall_fe   = reset & ~dmem_busy & ~ex_branch_taken & ~flush_pend & (md_stall | load_use);
  end

  always_comb begin
    hold_pc     = hold_all | stall_fe;
    hold_if_id  = hold_all | stall_fe;
    hold_id_ex  = hold_all;
    hold_ex_mem = hold_all;
    hold_mem_wb = hold_all;
    flush_if_id = flush_fe;
    flush_id_ex = flush_fe | stall_fe;
  end

  always_comb begin
    state_d   = dmem_busy       ? MEM_WAIT :
                ex_branch_taken ? ((FLUSH_CYCLES > 1) ? FLUSH : RUN) :
                flush_pend      ? ((fl_cnt_q == FLUSH_CNT_W'(1)) ? RUN : FLUSH) :
                md_stall        ? MD_WAIT : RUN;
    fl_cnt_d  = dmem_busy       ? fl_cnt_q :
                ex_branch_taken ? FL_LOAD :
                flush_pend      ? fl_cnt_q - FLUSH_CNT_W'(1) : '0;
    to_cnt_d  = ~dmem_busy ? '0 : (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
    timeout_d = timeout_q | (dmem_busy & (to_cnt_q >= TO_LAST));
    stall_d   = (hold_pc & ~(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      state_q   <= RUN;
      fl_cnt_q  <= '0;
      to_cnt_q  <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fl_cnt_q  <= fl_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles = stall_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed spec scenarios plus random traffic against a priority-rule model
module tb_pipeline_hazard_controller;

  localparam int RW = 5;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 8;
  localparam int SAT = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_reads_hilo, ex_mem_read, ex_branch_taken, muldiv_busy, dmem_busy;
  logic          hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb, flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cycles;
  logic          mem_timeout;

  int n_chk = 0;
  int n_pass = 0;
  int m_fl = 0;
  int m_busy_run = 0;
  int m_stall = 0;
  int m_tmo = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_ADDR_W  (RW),
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT),
    .CNT_W       (CW)
  ) dut (
    .system_clock   (clk),
    .reset          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_reads_hilo  (id_reads_hilo),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .muldiv_busy    (muldiv_busy),
    .dmem_busy      (dmem_busy),
    .hold_pc        (hold_pc),
    .hold_if_id     (hold_if_id),
    .hold_id_ex     (hold_id_ex),
    .hold_ex_mem    (hold_ex_mem),
    .hold_mem_wb    (hold_mem_wb),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .stall_cycles   (stall_cycles),
    .mem_timeout    (mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urt, input logic hilo,
                       input logic mr, input logic [RW-1:0] ert, input logic br, input logic md, input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_reads_hilo = hilo;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br; muldiv_busy = md; dmem_busy = busy;
  endtask

  // Outputs ordered {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb, flush_if_id, flush_id_ex}
  task automatic step();
    logic [6:0] exp;
    logic lu;
    @(negedge clk);
    lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (!rst_n) exp = 7'b0000011;
    else if (dmem_busy) exp = 7'b1111100;
    else if (ex_branch_taken || m_fl > 0) exp = 7'b0000011;
    else if ((muldiv_busy && id_reads_hilo) || lu) exp = 7'b1100001;
    else exp = 7'b0000000;
    chk("outs", {25'd0, hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb, flush_if_id, flush_id_ex}, {25'd0, exp});
    chk("stall_cycles", {24'd0, stall_cycles}, m_stall);
    chk("mem_timeout", {31'd0, mem_timeout}, m_tmo);
    if (!rst_n) begin
      m_fl = 0; m_busy_run = 0; m_stall = 0; m_tmo = 0;
    end else begin
      if (exp[6] && m_stall < SAT) m_stall++;
      if (dmem_busy) begin
        m_busy_run++;
        if (m_busy_run >= MT) m_tmo = 1;
      end else begin
        m_busy_run = 0;
        if (ex_branch_taken) m_fl = FC - 1;
        else if (m_fl > 0) m_fl--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_left;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_stall", {24'd0, stall_cycles}, 0);
    chk("rst_tmo", {31'd0, mem_timeout}, 0);

    drive(8, 3, 0, 0, 1, 8, 0, 0, 0); step();
    drive(8, 3, 0, 0, 0, 8, 0, 0, 0); step();
    chk("t2_stall", {24'd0, stall_cycles}, 1);
    drive(0, 0, 1, 0, 1, 0, 0, 0, 0); step();
    drive(5, 9, 1, 0, 1, 9, 0, 0, 0); step();
    drive(5, 9, 0, 0, 1, 9, 0, 0, 0); step();
    chk("rt_stall", {24'd0, stall_cycles}, 2);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    step();

    drive(8, 3, 0, 0, 1, 8, 0, 0, 1); repeat (4) step();
    drive(8, 3, 0, 0, 1, 8, 0, 0, 0); step();
    chk("t4_stall", {24'd0, stall_cycles}, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); repeat (2) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    drive(0, 0, 0, 1, 0, 0, 0, 1, 0); repeat (6) step();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); repeat (6) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();
    chk("t6_tmo", {31'd0, mem_timeout}, 1);
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("t6_clr", {31'd0, mem_timeout}, 0);

    busy_left = 0;
    repeat (800) begin
      if (busy_left == 0 && $urandom_range(0, 5) == 0) busy_left = $urandom_range(1, 6);
      drive(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            1'($urandom), RW'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, busy_left > 0);
      if (busy_left > 0) busy_left--;
      rst_n = $urandom_range(0, 399) != 0;
      step();
    end

    rst_n = 1'b0; step();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 1, 0); repeat (260) step();
    chk("sat_stall", {24'd0, stall_cycles}, SAT);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
